load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning max cycles in WAIT before error response.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have req_valid  input  1  CPU access request.
REQ-005 SHALL have req_ready  output  1  unit can accept a request.
REQ-006 SHALL have req_write  input  1  1=store, 0=load.
REQ-007 SHALL have req_funct3  input  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-008 SHALL have req_addr  input  25  byte address.
REQ-009 SHALL have req_wdata  input  32  store data, low bytes used.
REQ-010 SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have resp_err  output  1  misaligned, illegal funct3, or timeout.
REQ-013 SHALL have mem_enable  output  1  one-cycle RAM request strobe.
REQ-014 SHALL have mem_valid  input  1  RAM completion, one cycle after mem_enable.
REQ-015 SHALL have mem_addr  output  25, mem_oplen  output  2, mem_writeEnable  output  1, mem_data  output  32: RAM request fields.
REQ-016 SHALL have mem_result  input  32  RAM read data, zero-extended.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; req_ready = (state == IDLE).
REQ-018 SHALL accept a request when req_valid && req_ready, capturing write, funct3, addr, wdata.
REQ-019 SHALL, on legal accept, enter ISSUE; in ISSUE assert mem_enable for exactly one cycle with captured fields, then enter WAIT.
REQ-020 SHALL map oplen: byte 2'b00, half 2'b01, word 2'b11; never drive 2'b10.
REQ-021 SHALL hold mem_addr, mem_oplen, mem_writeEnable, mem_data stable from ISSUE through WAIT.
REQ-022 SHALL, in WAIT with mem_valid=1, register extended mem_result (loads) or 0 (stores) and enter RESP with resp_err=0.
REQ-023 SHALL extend loads: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
REQ-024 SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES without mem_valid, enter RESP with resp_err=1, resp_rdata=0.
REQ-025 SHALL treat as error (skip ISSUE/WAIT, go directly to RESP, resp_err=1, no mem_enable): half with addr[0]=1, word with addr[1:0]!=0, funct3 011/110/111, or store funct3 100/101.
REQ-026 SHALL assert resp_valid for exactly one cycle, in RESP only; RESP always returns to IDLE.
REQ-027 SHALL ignore mem_valid outside WAIT; if mem_valid and timeout coincide, mem_valid wins.
REQ-028 SHALL give legal-access latency: accept cycle N, mem_enable N+1, mem_valid N+2, resp_valid N+3; error response at N+1.
REQ-029 SHALL ignore req_valid outside IDLE; no new acceptance in the RESP cycle.

Reset
REQ-030 SHALL on rst=1 enter IDLE, clear timeout counter; outputs: req_ready 0 during rst then 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_enable 0, mem_addr 0, mem_oplen 0, mem_writeEnable 0, mem_data 0.
REQ-031 SHALL abandon any in-flight access on rst, issuing no response; a late mem_valid is ignored.

Structure
REQ-032 SHALL place state enum, funct3 constants and oplen constants in shared package lsu_pkg.
REQ-033 SHALL implement extension in combinational sub-module load_extender (funct3, raw 32b in, extended 32b out).

Verification
REQ-034 LW addr 36 against RAM reset image -> mem_oplen 11, resp_rdata 0xFEB516E3, resp_valid 3 cycles after accept.
REQ-035 LB addr 0 -> 0xFFFFFF93; LBU addr 0 -> 0x00000093; LHU addr 2 -> 0x00000010.
REQ-036 SW addr 64 data 0xDEADBEEF, then LW 64 -> 0xDEADBEEF; store resp_rdata 0, resp_err 0.
REQ-037 LH addr 1, SW addr 6, funct3 011 -> resp_err 1 next cycle, mem_enable never asserted.
REQ-038 mem_valid tied 0 -> resp_err 1 after 15 WAIT cycles; rst asserted in WAIT -> no resp_valid, IDLE, all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the FSM state, RV32I width codes and RAM oplen codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] OPLEN_B = 2'b00;
  localparam logic [1:0] OPLEN_H = 2'b01;
  localparam logic [1:0] OPLEN_W = 2'b11;

  function automatic logic f3_legal(
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !a[0];
      F3_W:    ok = (a == 2'b00);
      F3_BU:   ok = !wr;
      F3_HU:   ok = !wr && !a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // 2'b10 is never produced: anything not byte/half maps to word.
  function automatic logic [1:0] f3_oplen(input logic [2:0] f3);
    logic [1:0] ol;
    ol = OPLEN_W;
    if (f3[1:0] == 2'b00) ol = OPLEN_B;
    else if (f3[1:0] == 2'b01) ol = OPLEN_H;
    return ol;
  endfunction

endpackage

// File: rtl/load_extender.sv
// Sign/zero extension of raw RAM read data.
// Purely combinational; selected by the load funct3.
module load_extender
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ext = {24'b0, raw[7:0]};
      F3_HU:   ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit in front of a RAM.
// IDLE -> ISSUE -> WAIT -> RESP, with early error responses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [24:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_enable,
  input  logic        mem_valid,
  output logic [24:0] mem_addr,
  output logic [1:0]  mem_oplen,
  output logic        mem_writeEnable,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_result
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [24:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  oplen_q, oplen_d;
  logic        en_q, en_d;
  logic        rv_q, rv_d;
  logic [31:0] rd_q, rd_d;
  logic        re_q, re_d;
  logic [31:0] ext;

  load_extender u_ext (
    .funct3 (f3_q),
    .raw    (mem_result),
    .ext    (ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    data_d  = data_q;
    oplen_d = oplen_q;
    en_d    = 1'b0;
    rv_d    = 1'b0;
    rd_d    = '0;
    re_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          data_d  = req_wdata;
          oplen_d = f3_oplen(req_funct3);
          if (f3_legal(req_write, req_funct3, req_addr[1:0])) begin
            state_d = S_ISSUE;
            en_d    = 1'b1;
          end else begin
            state_d = S_RESP;
            rv_d    = 1'b1;
            re_d    = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // mem_valid takes priority over an expiring timeout
        if (mem_valid) begin
          state_d = S_RESP;
          rv_d    = 1'b1;
          rd_d    = wr_q ? 32'b0 : ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          rv_d    = 1'b1;
          re_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      oplen_q <= '0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      oplen_q <= oplen_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      re_q    <= re_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE) && !rst;
  assign resp_valid      = rv_q;
  assign resp_rdata      = rd_q;
  assign resp_err        = re_q;
  assign mem_enable      = en_q;
  assign mem_addr        = addr_q;
  assign mem_oplen       = oplen_q;
  assign mem_writeEnable = wr_q;
  assign mem_data        = data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural RAM
// and a byte-array reference model of memory contents.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [24:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_enable, mem_writeEnable;
  logic        mem_valid = 1'b0;
  logic [24:0] mem_addr;
  logic [1:0]  mem_oplen;
  logic [31:0] mem_data;
  logic [31:0] mem_result = '0;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  int ram_delay = 1;
  bit ram_mute = 1'b0;
  int pend_cnt = 0;
  logic [31:0] pend_res = '0;
  logic [31:0] ram_r;
  int ram_n;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_enable(mem_enable),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_oplen(mem_oplen), .mem_writeEnable(mem_writeEnable),
    .mem_data(mem_data), .mem_result(mem_result)
  );

  // RAM: answers ram_delay cycles after mem_enable unless muted
  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
      if (pend_cnt == 1 && !ram_mute) begin
        mem_valid  <= 1'b1;
        mem_result <= pend_res;
      end
    end
    if (mem_enable) begin
      ram_n = (mem_oplen == 2'b00) ? 1 : (mem_oplen == 2'b01) ? 2 : 4;
      ram_r = '0;
      for (int i = 0; i < 4; i++) begin
        if (i < ram_n) begin
          if (mem_writeEnable)
            ram[8'(mem_addr[7:0] + i)] = mem_data[8*i +: 8];
          ram_r[8*i +: 8] = ram[8'(mem_addr[7:0] + i)];
        end
      end
      if (ram_delay <= 1) begin
        if (!ram_mute) begin
          mem_valid  <= 1'b1;
          mem_result <= ram_r;
        end
      end else begin
        pend_cnt <= ram_delay - 1;
        pend_res <= ram_r;
      end
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_legal(input logic w, input logic [2:0] f3,
                                  input logic [24:0] a);
    int sz;
    sz = size_of(f3);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 0;
    if (w && f3[2]) return 0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [24:0] a);
    longint v;
    int sz;
    sz = size_of(f3);
    v = 0;
    for (int i = 0; i < sz; i++)
      v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v -= longint'(1) << (8 * sz);
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [24:0] a,
                           input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++)
      ref_mem[(a + i) % 256] = wd[8*i +: 8];
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ram[a + i]     = w[8*i +: 8];
      ref_mem[a + i] = w[8*i +: 8];
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    put_word(0, 32'h0010_0093);
    put_word(36, 32'hFEB5_16E3);
  endtask

  task automatic run_access(
    input  logic w, input logic [2:0] f3,
    input  logic [24:0] a, input logic [31:0] wd,
    output int en_cnt, output int en_cyc,
    output int rv_cnt, output int rv_cyc,
    output logic [31:0] rd, output logic er,
    output logic [1:0] ol, output logic [24:0] ma,
    output logic [31:0] md, output logic mw,
    output bit stable
  );
    int guard;
    en_cnt = 0; en_cyc = -1; rv_cnt = 0; rv_cyc = -1;
    rd = '0; er = 1'b0; ol = '0; ma = '0; md = '0; mw = 1'b0;
    stable = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom);
    req_funct3 = 3'($urandom); req_addr = 25'($urandom);
    req_wdata = $urandom;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (mem_enable) begin
        en_cnt++; en_cyc = c; ol = mem_oplen;
        ma = mem_addr; md = mem_data; mw = mem_writeEnable;
      end else if (en_cnt > 0 && rv_cyc < 0 &&
                   (mem_addr !== ma || mem_oplen !== ol ||
                    mem_data !== md || mem_writeEnable !== mw)) begin
        stable = 1'b0;
      end
      if (resp_valid) begin
        rv_cnt++;
        if (rv_cyc < 0) begin
          rv_cyc = c; rd = resp_rdata; er = resp_err;
        end
      end
      if (rv_cyc > 0 && c >= rv_cyc + 2) break;
    end
  endtask

  int en_cnt, en_cyc, rv_cnt, rv_cyc;
  logic [31:0] rd, md;
  logic er, mw;
  logic [1:0] ol;
  logic [24:0] ma;
  bit stable;

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0", req_ready);
    end
    checks++;
    if ({resp_valid, resp_rdata, resp_err, mem_enable, mem_addr,
         mem_oplen, mem_writeEnable, mem_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs rv=%b rd=%h re=%b en=%b a=%h ol=%b we=%b d=%h want all 0",
               resp_valid, resp_rdata, resp_err, mem_enable, mem_addr,
               mem_oplen, mem_writeEnable, mem_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_reset_image();
    run_access(1'b0, 3'b010, 25'd36, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    checks++;
    if (ol !== 2'b11) begin
      failures++; $display("FAIL lw36_oplen got=%b want=11", ol);
    end
    checks++;
    if (rd !== 32'hFEB516E3 || er !== 1'b0) begin
      failures++;
      $display("FAIL lw36_data got=%h err=%b want=feb516e3 err=0", rd, er);
    end
    checks++;
    if (en_cyc !== 1 || en_cnt !== 1 || rv_cyc !== 3 || rv_cnt !== 1) begin
      failures++;
      $display("FAIL lw36_timing en@%0d x%0d rv@%0d x%0d want en@1 x1 rv@3 x1",
               en_cyc, en_cnt, rv_cyc, rv_cnt);
    end
    checks++;
    if (!stable || ma !== 25'd36) begin
      failures++;
      $display("FAIL lw36_fields stable=%0d addr=%h want stable=1 addr=24", stable, ma);
    end
    run_access(1'b0, 3'b000, 25'd0, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    checks++;
    if (rd !== 32'hFFFFFF93 || ol !== 2'b00) begin
      failures++;
      $display("FAIL lb0 got=%h ol=%b want=ffffff93 ol=00", rd, ol);
    end
    run_access(1'b0, 3'b100, 25'd0, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    checks++;
    if (rd !== 32'h00000093) begin
      failures++; $display("FAIL lbu0 got=%h want=00000093", rd);
    end
    run_access(1'b0, 3'b101, 25'd2, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    checks++;
    if (rd !== 32'h00000010 || ol !== 2'b01) begin
      failures++;
      $display("FAIL lhu2 got=%h ol=%b want=00000010 ol=01", rd, ol);
    end
  endtask

  task automatic test_store_load();
    run_access(1'b1, 3'b010, 25'd64, 32'hDEADBEEF, en_cnt, en_cyc,
               rv_cnt, rv_cyc, rd, er, ol, ma, md, mw, stable);
    ref_store(3'b010, 25'd64, 32'hDEADBEEF);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || rv_cyc !== 3) begin
      failures++;
      $display("FAIL sw64_resp rd=%h err=%b rv@%0d want 0 0 @3", rd, er, rv_cyc);
    end
    checks++;
    if (mw !== 1'b1 || md !== 32'hDEADBEEF || ol !== 2'b11) begin
      failures++;
      $display("FAIL sw64_mem we=%b d=%h ol=%b want 1 deadbeef 11", mw, md, ol);
    end
    run_access(1'b0, 3'b010, 25'd64, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw64 got=%h want=deadbeef", rd);
    end
  endtask

  task automatic test_errors();
    logic [2:0] f3s [4];
    logic ws [4];
    logic [24:0] as [4];
    f3s = '{3'b001, 3'b010, 3'b011, 3'b100};
    ws  = '{1'b0, 1'b1, 1'b0, 1'b1};
    as  = '{25'd1, 25'd6, 25'd8, 25'd12};
    for (int i = 0; i < 4; i++) begin
      run_access(ws[i], f3s[i], as[i], 32'h1234_5678, en_cnt, en_cyc,
                 rv_cnt, rv_cyc, rd, er, ol, ma, md, mw, stable);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || rv_cyc !== 1 || rv_cnt !== 1 ||
          en_cnt !== 0) begin
        failures++;
        $display("FAIL err_case%0d err=%b rd=%h rv@%0d x%0d en=%0d want 1 0 @1 x1 en=0",
                 i, er, rd, rv_cyc, rv_cnt, en_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    ram_mute = 1'b1;
    run_access(1'b0, 3'b010, 25'd4, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    ram_mute = 1'b0;
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || rv_cyc !== 17 || en_cnt !== 1 ||
        !stable) begin
      failures++;
      $display("FAIL timeout err=%b rd=%h rv@%0d en=%0d st=%0d want 1 0 @17 1 1",
               er, rd, rv_cyc, en_cnt, stable);
    end
    ram_delay = 15;
    run_access(1'b0, 3'b010, 25'd36, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    checks++;
    if (er !== 1'b0 || rd !== 32'hFEB516E3 || rv_cyc !== 17) begin
      failures++;
      $display("FAIL late_valid_wins err=%b rd=%h rv@%0d want 0 feb516e3 @17",
               er, rd, rv_cyc);
    end
    ram_delay = 16;
    run_access(1'b0, 3'b010, 25'd36, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    ram_delay = 1;
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || rv_cyc !== 17 || rv_cnt !== 1) begin
      failures++;
      $display("FAIL too_late err=%b rd=%h rv@%0d x%0d want 1 0 @17 x1",
               er, rd, rv_cyc, rv_cnt);
    end
  endtask

  task automatic test_reset_inflight();
    int rvs, ens;
    rvs = 0; ens = 0;
    ram_delay = 5;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 25'd8; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (resp_valid) rvs++;
      if (mem_enable) ens++;
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        checks++;
        if (req_ready !== 1'b0 ||
            {resp_valid, resp_rdata, resp_err, mem_enable, mem_addr,
             mem_oplen, mem_writeEnable, mem_data} !== '0) begin
          failures++;
          $display("FAIL rst_in_wait rdy=%b en=%b a=%h we=%b want rdy=0 all 0",
                   req_ready, mem_enable, mem_addr, mem_writeEnable);
        end
      end
      if (c == 4) rst = 1'b0;
      if (c == 5) begin
        checks++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL rst_in_wait_idle rdy=%b want=1", req_ready);
        end
      end
    end
    ram_delay = 1;
    checks++;
    if (rvs !== 0 || ens !== 1) begin
      failures++;
      $display("FAIL rst_abandon resp=%0d en=%0d want resp=0 en=1", rvs, ens);
    end
    run_access(1'b0, 3'b010, 25'd36, '0, en_cnt, en_cyc, rv_cnt, rv_cyc,
               rd, er, ol, ma, md, mw, stable);
    checks++;
    if (rd !== 32'hFEB516E3 || rv_cyc !== 3 || er !== 1'b0) begin
      failures++;
      $display("FAIL after_rst_lw rd=%h rv@%0d err=%b want feb516e3 @3 0",
               rd, rv_cyc, er);
    end
  endtask

  task automatic test_random();
    logic w;
    logic [2:0] f3;
    logic [24:0] a;
    logic [31:0] wd, exp_rd, mask;
    bit legal;
    int sz, bad;
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom); f3 = 3'($urandom);
      a = 25'($urandom); wd = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      sz = size_of(f3);
      legal = is_legal(w, f3, a);
      exp_rd = (legal && !w) ? ref_load(f3, a) : 32'h0;
      mask = (sz == 4) ? 32'hFFFFFFFF : 32'((longint'(1) << (8 * sz)) - 1);
      run_access(w, f3, a, wd, en_cnt, en_cyc, rv_cnt, rv_cyc,
                 rd, er, ol, ma, md, mw, stable);
      if (legal && w) ref_store(f3, a, wd);
      bad = 0;
      if (rd !== exp_rd || er !== !legal || rv_cnt !== 1) bad = 1;
      if (legal && (rv_cyc !== 3 || en_cnt !== 1 || ma !== a ||
                    mw !== w || !stable ||
                    ol !== ((sz == 1) ? 2'b00 : (sz == 2) ? 2'b01 : 2'b11)))
        bad = 1;
      if (legal && w && ((md ^ wd) & mask) != 0) bad = 1;
      if (!legal && (rv_cyc !== 1 || en_cnt !== 0)) bad = 1;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand%0d w=%b f3=%b a=%h got rd=%h err=%b rv@%0d en=%0d ol=%b want rd=%h err=%b",
                 n, w, f3, a, rd, er, rv_cyc, en_cnt, ol, exp_rd, !legal);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] en_m, rv_m, exp_en, exp_rv;
    en_m = '0; rv_m = '0; exp_en = '0; exp_rv = '0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 25'd36; req_wdata = '0;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      en_m[c] = mem_enable; rv_m[c] = resp_valid;
      if (c % 4 == 1) exp_en[c] = 1'b1;
      if (c % 4 == 3) exp_rv[c] = 1'b1;
    end
    req_valid = 1'b0;
    checks++;
    if (en_m !== exp_en || rv_m !== exp_rv) begin
      failures++;
      $display("FAIL b2b_legal en=%b rv=%b want en=%b rv=%b", en_m, rv_m, exp_en, exp_rv);
    end
    repeat (6) @(negedge clk);
    en_m = '0; rv_m = '0; exp_rv = '0;
    req_valid = 1'b1; req_funct3 = 3'b011; req_addr = 25'd0;
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      en_m[c] = mem_enable; rv_m[c] = resp_valid;
      if (c % 2 == 1) exp_rv[c] = 1'b1;
    end
    req_valid = 1'b0;
    checks++;
    if (en_m !== '0 || rv_m !== exp_rv) begin
      failures++;
      $display("FAIL b2b_err en=%b rv=%b want en=0 rv=%b", en_m, rv_m, exp_rv);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    init_mem();
    test_reset();
    test_reset_image();
    test_store_load();
    test_errors();
    test_timeout();
    test_reset_inflight();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
